bomb_fuse_scheduler: RTL and testbench
======================================

# bomb_fuse_scheduler

Shares the quarter-second tick among up to NUM_SLOTS live bombs. Each bomb placement arms a free fuse slot. The slot counts down FUSE_TICKS ticks, or expires early on a chain-reaction detonate request. Expired slots are released one at a time through a valid/ready explode handshake to the map/explosion logic. The block sits between the quarter-second tick generator and the game-logic bomb handling.

## Interface
- NUM_SLOTS, 4: number of concurrent bombs (2..16).
- FUSE_TICKS, 12: ticks from arm to expiry (≥1); 12 = 3 s at a quarter-second tick.
- BLINK_TICKS, 4: blink window length in ticks (only with FUSE_BLINK_EN; 1..FUSE_TICKS).
- SW: localparam = $clog2(NUM_SLOTS). CW: localparam = $clog2(FUSE_TICKS+1).
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse from the quarter-second counter.
- arm_req  in  1  place bomb; one cycle per bomb.
- arm_ack  out  1  registered; high one cycle after an accepted arm_req.
- arm_slot  out  SW  slot allocated; valid while arm_ack is high.
- full  out  1  no IDLE slot this cycle.
- detonate_req  in  1  force early expiry (chain reaction).
- detonate_slot  in  SW  target of detonate_req.
- explode_valid  out  1  at least one slot is PENDING.
- explode_slot  out  SW  lowest-index PENDING slot.
- explode_ready  in  1  consumer accepts explode_slot.
- active_mask  out  NUM_SLOTS  slot is ARMED or PENDING.
- blink_mask  out  NUM_SLOTS  only with FUSE_BLINK_EN.

## Operation
- Per-slot states: IDLE, ARMED, PENDING. Each slot holds a CW-bit count.
- IDLE→ARMED: at an edge where arm_req=1 and full=0, the lowest-index IDLE slot is loaded with count=FUSE_TICKS.
  - Next cycle: arm_ack=1 and arm_slot=that index.
  - arm_req while full=1 is dropped; arm_ack stays 0.
- ARMED, tick=1: count decrements. A decrement from 1 moves the slot to PENDING. A count of 0 is never held in ARMED.
- ARMED, detonate_req=1 with matching detonate_slot → PENDING, whatever the count.
  - detonate_req aimed at an IDLE or PENDING slot is ignored.
- tick and detonate on the same slot in the same cycle → PENDING once; no double event.
- A slot armed in a tick cycle is loaded with FUSE_TICKS and is not decremented in that cycle.
- PENDING→IDLE: at an edge where explode_valid & explode_ready. Only the slot on explode_slot is released. Other PENDING slots wait, lowest index first.
- A slot released this cycle is not available to arm_req until the next cycle. Allocation uses the current registered state.
- explode_valid, explode_slot, full and active_mask are combinational from the state registers.

## Timing
- Reset values: all slots IDLE, counts 0. arm_ack=0, arm_slot=0, explode_valid=0, explode_slot=0, full=0, active_mask=0, blink_mask=0.
- Reset mid-countdown discards all bombs; no explode is issued.
- Arm latency: arm_ack 1 cycle after arm_req.
- Expiry: PENDING is visible on explode_valid 1 cycle after the FUSE_TICKS-th tick, or after the detonate_req cycle.
- Explode throughput: one slot per cycle while explode_ready=1.
- A PENDING slot is held indefinitely while explode_ready=0. Its tick is frozen.

## Configuration
- FUSE_BLINK_EN defined: blink_mask port present.
  - Bit i toggles on each tick while slot i is ARMED with count ≤ BLINK_TICKS.
  - Bit i clears on entering PENDING or IDLE.
- FUSE_BLINK_EN undefined: no blink_mask port and no blink registers.

## Structure
- Package bomb_sched_pkg holds:
  - slot_state_t enum (IDLE, ARMED, PENDING).
  - Default NUM_SLOTS, FUSE_TICKS and BLINK_TICKS constants.
- Sub-module fuse_slot holds one slot's state, count and blink bit, and is instantiated NUM_SLOTS times. Inputs: load, tick, force, release.
- The top level holds the lowest-index IDLE allocator, the lowest-index PENDING arbiter, and the arm_ack/arm_slot registers.

## Test plan
- Reset, arm_req one cycle, 12 ticks → arm_ack with slot 0 next cycle; explode_valid with slot 0 one cycle after tick 12; ready=1 releases it, active_mask=0.
- Arm 4 bombs on consecutive cycles, then a 5th arm_req → slots 0..3 acked, full=1, 5th not acked.
- Arm slots 0 and 1 in the same cycle window, 12 ticks, explode_ready held 0 for 5 cycles then 1 → both pending; explode_slot=0 then 1 on consecutive cycles.
- Slot 2 armed, detonate_req slot 2 coinciding with a tick → single PENDING on slot 2. Detonate on IDLE slot 3 → no effect.
- arm_req in the same cycle as tick; release of slot 0 together with arm_req while full → new slot count=12; arm refused that cycle, succeeds next cycle on slot 0.
- FUSE_BLINK_EN: blink bit first toggles at the tick that brings count to 4; reset mid-countdown → all outputs 0, no explode.

Source files
------------

// File: rtl/bomb_fuse_scheduler_pkg.sv
// Shared types and defaults for the bomb fuse scheduler.
// Optional blink feature: FUSE_BLINK_EN.
package bomb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2
  } slot_state_t;

  localparam int DEF_NUM_SLOTS   = 4;
  localparam int DEF_FUSE_TICKS  = 12;
  localparam int DEF_BLINK_TICKS = 4;

endpackage

// File: rtl/bomb_fuse_scheduler_if.sv
// Explode handshake between the scheduler and the map logic.
// Optional blink feature: FUSE_BLINK_EN.
interface bomb_fuse_scheduler_if #(
  parameter int SW = 2
);
  logic          explode_valid;
  logic [SW-1:0] explode_slot;
  logic          explode_ready;

  modport master (
    output explode_valid,
    output explode_slot,
    input  explode_ready
  );

  modport slave (
    input  explode_valid,
    input  explode_slot,
    output explode_ready
  );
endinterface

// File: rtl/bomb_fuse_scheduler_fuse_slot.sv
// One bomb fuse: IDLE -> ARMED (countdown) -> PENDING -> IDLE.
// Optional blink bit under FUSE_BLINK_EN.
module fuse_slot
  import bomb_sched_pkg::*;
#(
  parameter int FUSE_TICKS  = DEF_FUSE_TICKS,
`ifdef FUSE_BLINK_EN
  parameter int BLINK_TICKS = DEF_BLINK_TICKS,
`endif
  parameter int CW          = $clog2(FUSE_TICKS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  input  logic force_exp,
  input  logic release_exp,
  output logic is_idle,
  output logic is_active,
  output logic is_pending
`ifdef FUSE_BLINK_EN
  ,
  output logic blink
`endif
);

  slot_state_t   state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // State and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: force wins over tick so a slot expires once
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = ARMED;
          count_d = CW'(FUSE_TICKS);
        end
      end
      ARMED: begin
        if (force_exp) begin
          state_d = PENDING;
          count_d = '0;
        end else if (tick) begin
          if (count_q == CW'(1)) begin
            state_d = PENDING;
            count_d = '0;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end
      PENDING: begin
        if (release_exp) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Status decode from the registered state
  always_comb begin
    is_idle    = (state_q == IDLE);
    is_pending = (state_q == PENDING);
    is_active  = (state_q == ARMED) || (state_q == PENDING);
  end

`ifdef FUSE_BLINK_EN
  logic blink_q, blink_d;

  // Blink register
  always_ff @(posedge clk) begin
    if (reset) blink_q <= 1'b0;
    else       blink_q <= blink_d;
  end

  // Toggle on ticks inside the final window, clear once no longer armed
  always_comb begin
    blink_d = blink_q;
    if (state_d != ARMED) begin
      blink_d = 1'b0;
    end else if (state_q == ARMED && tick && !force_exp &&
                 count_d <= CW'(BLINK_TICKS)) begin
      blink_d = ~blink_q;
    end
  end

  assign blink = blink_q;
`endif

endmodule

// File: rtl/bomb_fuse_scheduler.sv
// Shares the quarter-second tick among NUM_SLOTS bomb fuses.
// Optional blink_mask output: define FUSE_BLINK_EN.
module bomb_fuse_scheduler
  import bomb_sched_pkg::*;
#(
  parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
`ifdef FUSE_BLINK_EN
  parameter int BLINK_TICKS = DEF_BLINK_TICKS,
`endif
  parameter int FUSE_TICKS  = DEF_FUSE_TICKS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          arm_req,
  output logic                          arm_ack,
  output logic [$clog2(NUM_SLOTS)-1:0]  arm_slot,
  output logic                          full,
  input  logic                          detonate_req,
  input  logic [$clog2(NUM_SLOTS)-1:0]  detonate_slot,
  bomb_fuse_scheduler_if.master         xp,
  output logic [NUM_SLOTS-1:0]          active_mask
`ifdef FUSE_BLINK_EN
  ,
  output logic [NUM_SLOTS-1:0]          blink_mask
`endif
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(FUSE_TICKS + 1);

  logic [NUM_SLOTS-1:0] idle_v, pend_v, act_v;
  logic [NUM_SLOTS-1:0] load_v, force_v, rel_v;
  logic                 alloc_found, pend_found;
  logic [SW-1:0]        alloc_idx, pend_idx;
  logic                 arm_acc;
  logic                 arm_ack_q, arm_ack_d;
  logic [SW-1:0]        arm_slot_q, arm_slot_d;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    fuse_slot #(
      .FUSE_TICKS  (FUSE_TICKS),
`ifdef FUSE_BLINK_EN
      .BLINK_TICKS (BLINK_TICKS),
`endif
      .CW          (CW)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .load        (load_v[g]),
      .tick        (tick),
      .force_exp   (force_v[g]),
      .release_exp (rel_v[g]),
      .is_idle     (idle_v[g]),
      .is_active   (act_v[g]),
      .is_pending  (pend_v[g])
`ifdef FUSE_BLINK_EN
      ,
      .blink       (blink_mask[g])
`endif
    );
  end

  // Lowest-index IDLE slot for the next arm request
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idle_v[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = SW'(i);
      end
    end
  end

  // Lowest-index PENDING slot offered on the explode handshake
  always_comb begin
    pend_found = 1'b0;
    pend_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (pend_v[i] && !pend_found) begin
        pend_found = 1'b1;
        pend_idx   = SW'(i);
      end
    end
  end

  assign full             = ~alloc_found;
  assign arm_acc          = arm_req & ~full;
  assign xp.explode_valid = pend_found;
  assign xp.explode_slot  = pend_idx;
  assign active_mask      = act_v;

  // Per-slot load / force / release strobes
  always_comb begin
    load_v  = '0;
    force_v = '0;
    rel_v   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      load_v[i]  = arm_acc && (alloc_idx == SW'(i));
      force_v[i] = detonate_req && (detonate_slot == SW'(i));
      rel_v[i]   = pend_found && xp.explode_ready &&
                   (pend_idx == SW'(i));
    end
  end

  // Arm acknowledge next state
  always_comb begin
    arm_ack_d  = arm_acc;
    arm_slot_d = arm_acc ? alloc_idx : arm_slot_q;
  end

  // Arm acknowledge registers
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_ack_q  <= 1'b0;
      arm_slot_q <= '0;
    end else begin
      arm_ack_q  <= arm_ack_d;
      arm_slot_q <= arm_slot_d;
    end
  end

  assign arm_ack  = arm_ack_q;
  assign arm_slot = arm_slot_q;

endmodule

// File: tb/tb_bomb_fuse_scheduler.sv
// Directed bench for bomb_fuse_scheduler.
// Blink checks compiled in with FUSE_BLINK_EN.
module tb_bomb_fuse_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       arm_req;
  logic       arm_ack;
  logic [1:0] arm_slot;
  logic       full;
  logic       detonate_req;
  logic [1:0] detonate_slot;
  logic [3:0] active_mask;
`ifdef FUSE_BLINK_EN
  logic [3:0] blink_mask;
`endif

  int checks   = 0;
  int failures = 0;

  bomb_fuse_scheduler_if #(.SW(2)) xif ();

  bomb_fuse_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .arm_req       (arm_req),
    .arm_ack       (arm_ack),
    .arm_slot      (arm_slot),
    .full          (full),
    .detonate_req  (detonate_req),
    .detonate_slot (detonate_slot),
    .xp            (xif.master),
    .active_mask   (active_mask)
`ifdef FUSE_BLINK_EN
    ,
    .blink_mask    (blink_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       arm;
    logic       det;
    logic [1:0] dslot;
    logic       rdy;
    logic       e_ack;
    logic [1:0] e_aslot;
    logic       e_full;
    logic       e_ev;
    logic [1:0] e_es;
    logic [3:0] e_act;
  } vec_t;

  vec_t tbl [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    tick = 0; arm_req = 0; detonate_req = 0;
    detonate_slot = 0; xif.explode_ready = 0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic pulse_tick();
    tick = 1; step(); tick = 0;
  endtask

  initial begin
    //        tk arm det ds rdy ack as full ev es act
    tbl[0]  = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0001};
    tbl[1]  = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0011};
    tbl[2]  = '{0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 4'b0111};
    tbl[3]  = '{0, 1, 0, 0, 0, 1, 3, 1, 0, 0, 4'b1111};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 4'b1111};
    tbl[5]  = '{1, 0, 1, 2, 0, 0, 3, 1, 1, 2, 4'b1111};
    tbl[6]  = '{0, 0, 1, 2, 0, 0, 3, 1, 1, 2, 4'b1111};
    tbl[7]  = '{0, 1, 0, 0, 1, 0, 3, 0, 0, 0, 4'b1011};
    tbl[8]  = '{0, 1, 0, 0, 0, 1, 2, 1, 0, 0, 4'b1111};
    tbl[9]  = '{0, 0, 1, 1, 1, 0, 2, 1, 1, 1, 4'b1111};
    tbl[10] = '{0, 0, 1, 0, 0, 0, 2, 1, 1, 0, 4'b1111};
    tbl[11] = '{0, 0, 0, 0, 1, 0, 2, 0, 1, 1, 4'b1110};
    tbl[12] = '{0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 4'b1100};
    tbl[13] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101};
    tbl[14] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'b1101};

    do_reset();
    chk("rst_ack",  arm_ack, 0);
    chk("rst_slot", arm_slot, 0);
    chk("rst_ev",   xif.explode_valid, 0);
    chk("rst_es",   xif.explode_slot, 0);
    chk("rst_full", full, 0);
    chk("rst_act",  active_mask, 0);
`ifdef FUSE_BLINK_EN
    chk("rst_blink", blink_mask, 0);
`endif

    // Table: fill, overflow, detonate, release ordering
    for (int i = 0; i < 15; i++) begin
      tick = tbl[i].tick;
      arm_req = tbl[i].arm;
      detonate_req = tbl[i].det;
      detonate_slot = tbl[i].dslot;
      xif.explode_ready = tbl[i].rdy;
      step();
      idle_in();
      chk($sformatf("t%0d_ack", i), arm_ack, tbl[i].e_ack);
      chk($sformatf("t%0d_aslot", i), arm_slot, tbl[i].e_aslot);
      chk($sformatf("t%0d_full", i), full, tbl[i].e_full);
      chk($sformatf("t%0d_ev", i), xif.explode_valid, tbl[i].e_ev);
      if (tbl[i].e_ev)
        chk($sformatf("t%0d_es", i), xif.explode_slot, tbl[i].e_es);
      chk($sformatf("t%0d_act", i), active_mask, tbl[i].e_act);
    end

    // Single bomb, armed in a tick cycle, full 12-tick countdown
    do_reset();
    arm_req = 1; tick = 1; step(); idle_in();
    chk("s1_ack", arm_ack, 1);
    chk("s1_slot", arm_slot, 0);
    for (int k = 1; k <= 12; k++) begin
      pulse_tick();
      chk($sformatf("s1_ev_tick%0d", k), xif.explode_valid,
          (k == 12) ? 1 : 0);
      step();
    end
    chk("s1_es", xif.explode_slot, 0);
    xif.explode_ready = 1; step(); idle_in();
    chk("s1_ev_rel", xif.explode_valid, 0);
    chk("s1_act_rel", active_mask, 0);

    // Two bombs expire together, consumer stalls then drains
    do_reset();
    arm_req = 1; step(); step(); idle_in();
    for (int k = 1; k <= 12; k++) pulse_tick();
    chk("s2_act", active_mask, 4'b0011);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("s2_hold_ev%0d", k), xif.explode_valid, 1);
      chk($sformatf("s2_hold_es%0d", k), xif.explode_slot, 0);
    end
    xif.explode_ready = 1;
    step();
    chk("s2_es1", xif.explode_slot, 1);
    chk("s2_ev1", xif.explode_valid, 1);
    step(); idle_in();
    chk("s2_ev_done", xif.explode_valid, 0);
    chk("s2_act_done", active_mask, 0);

    // Release while full: arm refused that cycle, succeeds next
    do_reset();
    arm_req = 1;
    for (int k = 0; k < 4; k++) step();
    idle_in();
    chk("s3_full", full, 1);
    detonate_req = 1; detonate_slot = 0; step(); idle_in();
    chk("s3_ev", xif.explode_valid, 1);
    arm_req = 1; xif.explode_ready = 1; step();
    xif.explode_ready = 0;
    chk("s3_ack_refused", arm_ack, 0);
    chk("s3_full_rel", full, 0);
    chk("s3_act_rel", active_mask, 4'b1110);
    step(); idle_in();
    chk("s3_ack_ok", arm_ack, 1);
    chk("s3_slot_ok", arm_slot, 0);
    for (int k = 1; k <= 12; k++) begin
      pulse_tick();
      chk($sformatf("s3_ev_tick%0d", k), xif.explode_valid,
          (k == 12) ? 1 : 0);
    end
    chk("s3_es", xif.explode_slot, 0);
    xif.explode_ready = 1;
    for (int k = 0; k < 4; k++) step();
    idle_in();
    chk("s3_drain", active_mask, 0);

    // Reset mid-countdown discards everything
    do_reset();
    arm_req = 1; step(); idle_in();
    chk("s4_ack", arm_ack, 1);
    for (int k = 0; k < 5; k++) pulse_tick();
    reset = 1; step(); reset = 0;
    chk("s4_ack_rst", arm_ack, 0);
    chk("s4_act_rst", active_mask, 0);
    chk("s4_ev_rst", xif.explode_valid, 0);
    for (int k = 0; k < 15; k++) pulse_tick();
    chk("s4_no_explode", xif.explode_valid, 0);
    chk("s4_act_end", active_mask, 0);

`ifdef FUSE_BLINK_EN
    // Blink starts at the tick that brings the count to 4
    do_reset();
    arm_req = 1; step(); idle_in();
    for (int k = 1; k <= 12; k++) begin
      pulse_tick();
      chk($sformatf("b_tick%0d", k), blink_mask,
          (k >= 8 && k <= 11) ? ((k % 2 == 0) ? 1 : 0) : 0);
    end
    chk("b_pending", xif.explode_valid, 1);
    do_reset();
    arm_req = 1; step(); idle_in();
    for (int k = 0; k < 8; k++) pulse_tick();
    chk("b_on", blink_mask, 1);
    reset = 1; step(); reset = 0;
    chk("b_rst", blink_mask, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
